// File: rtl/gemm_pkg.sv
// Shared defaults and element-slicing helpers for the GEMM operator.
package gemm_pkg;

    localparam int DEF_INP_WIDTH = 8;
    localparam int DEF_WGT_WIDTH = 8;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_BLOCK     = 16;

    // Low bit of element idx in a flat vector of width-bit elements.
    function automatic int elem_lo(input int idx, input int width);
        return idx * width;
    endfunction

    // Flat element index of w[m][n] in a block x block row-major matrix.
    function automatic int wgt_idx(input int m, input int n, input int block);
        return m * block + n;
    endfunction

endpackage

// File: rtl/gemm_dot_row.sv
// One output row: registered products (stage 1), then sum of products plus
// the accumulator element registered as the row result (stage 2).
module gemm_dot_row
    import gemm_pkg::*;
#(
    parameter int INP_WIDTH = DEF_INP_WIDTH,
    parameter int WGT_WIDTH = DEF_WGT_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int BLOCK     = DEF_BLOCK
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         commit,
    input  logic [INP_WIDTH*BLOCK-1:0]   i_vec,
    input  logic [WGT_WIDTH*BLOCK-1:0]   w_row,
    input  logic [ACC_WIDTH-1:0]         a_elem,
    output logic [ACC_WIDTH-1:0]         o_elem
);

    localparam int PROD_WIDTH = INP_WIDTH + WGT_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod_reg [BLOCK];
    logic signed [ACC_WIDTH-1:0]  a_reg;
    logic signed [ACC_WIDTH-1:0]  sum_next;
    logic signed [ACC_WIDTH-1:0]  o_reg;

    // Stage 1: capture full-precision signed products and the accumulator copy.
    // Data only, no reset: validity is tracked by the top-level valid pipeline.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int n = 0; n < BLOCK; n++) begin
                prod_reg[n] <= PROD_WIDTH'($signed(i_vec[elem_lo(n, INP_WIDTH) +: INP_WIDTH]))
                             * PROD_WIDTH'($signed(w_row[elem_lo(n, WGT_WIDTH) +: WGT_WIDTH]));
            end
            a_reg <= a_elem;
        end
    end

    // Row reduction: sign-extend each product and add, wrapping at ACC_WIDTH.
    always_comb begin
        sum_next = a_reg;
        for (int n = 0; n < BLOCK; n++) begin
            sum_next = sum_next + ACC_WIDTH'(prod_reg[n]);
        end
    end

    // Stage 2: result register; holds its value unless a valid op arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_reg <= '0;
        end else if (commit) begin
            o_reg <= sum_next;
        end
    end

    assign o_elem = o_reg;

endmodule

// File: rtl/gemm_op.sv
// Two-stage pipelined BLOCK x BLOCK matrix-vector multiply-accumulate.
// Rows are computed by gemm_dot_row instances; this level owns validity.
module gemm_op
    import gemm_pkg::*;
#(
    parameter int INP_WIDTH = DEF_INP_WIDTH,
    parameter int WGT_WIDTH = DEF_WGT_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int BLOCK     = DEF_BLOCK
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [INP_WIDTH*BLOCK-1:0]         i_tensor,
    input  logic [WGT_WIDTH*BLOCK*BLOCK-1:0]   w_tensor,
    input  logic [ACC_WIDTH*BLOCK-1:0]         a_tensor,
    output logic                               out_valid,
    output logic [ACC_WIDTH*BLOCK-1:0]         o_tensor
);

    logic valid_s1_reg;
    logic out_valid_reg;

    // Valid pipeline: reset drops anything in flight and ignores in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_s1_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            valid_s1_reg  <= in_valid;
            out_valid_reg <= valid_s1_reg;
        end
    end

    assign out_valid = out_valid_reg;

    generate
        for (genvar gi = 0; gi < BLOCK; gi++) begin : g_row
            gemm_dot_row #(
                .INP_WIDTH (INP_WIDTH),
                .WGT_WIDTH (WGT_WIDTH),
                .ACC_WIDTH (ACC_WIDTH),
                .BLOCK     (BLOCK)
            ) u_row (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (in_valid),
                .commit (valid_s1_reg),
                .i_vec  (i_tensor),
                .w_row  (w_tensor[elem_lo(wgt_idx(gi, 0, BLOCK), WGT_WIDTH) +: WGT_WIDTH*BLOCK]),
                .a_elem (a_tensor[elem_lo(gi, ACC_WIDTH) +: ACC_WIDTH]),
                .o_elem (o_tensor[elem_lo(gi, ACC_WIDTH) +: ACC_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gemm_op.sv
// Directed bench for gemm_op: inputs driven and outputs sampled on negedge.
module tb_gemm_op;

    localparam int IW = 8;
    localparam int WW = 8;
    localparam int AW = 32;
    localparam int B  = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [IW*B-1:0]      i_tensor;
    logic [WW*B*B-1:0]    w_tensor;
    logic [AW*B-1:0]      a_tensor;
    logic                 out_valid;
    logic [AW*B-1:0]      o_tensor;

    logic [AW*B-1:0]      exp_o;
    logic [AW*B-1:0]      exp_s [3];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gemm_op #(
        .INP_WIDTH (IW),
        .WGT_WIDTH (WW),
        .ACC_WIDTH (AW),
        .BLOCK     (B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .i_tensor  (i_tensor),
        .w_tensor  (w_tensor),
        .a_tensor  (a_tensor),
        .out_valid (out_valid),
        .o_tensor  (o_tensor)
    );

    task automatic clear_ops();
        i_tensor = '0;
        w_tensor = '0;
        a_tensor = '0;
    endtask

    task automatic set_identity_w();
        w_tensor = '0;
        for (int m = 0; m < B; m++) w_tensor[(m*B+m)*WW +: WW] = 8'd1;
    endtask

    // Drives the current operands for one cycle, then checks latency and result.
    task automatic run_single(input string name);
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_early_valid got=%b want=0", name, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid got=%b want=1", name, out_valid);
        end
        checks++;
        if (o_tensor !== exp_o) begin
            failures++;
            $display("FAIL %s_data got=%h want=%h", name, o_tensor, exp_o);
        end
        $display("txn %s out_valid=%b o[0]=%h o[3]=%h", name, out_valid, o_tensor[0 +: AW], o_tensor[3*AW +: AW]);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < B; n++) i_tensor[n*IW +: IW] = 8'd1;
        set_identity_w();
        a_tensor = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        checks++;
        if (o_tensor !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", o_tensor);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ignore_in_valid got=%b want=0", out_valid);
        end
        $display("txn reset out_valid=%b", out_valid);
    endtask

    task automatic test_identity();
        clear_ops();
        for (int n = 0; n < B; n++) i_tensor[n*IW +: IW] = IW'(n + 1);
        set_identity_w();
        for (int m = 0; m < B; m++) exp_o[m*AW +: AW] = AW'(m + 1);
        run_single("identity");
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || o_tensor !== exp_o) begin
            failures++;
            $display("FAIL identity_hold got_valid=%b got=%h want_valid=0 want=%h", out_valid, o_tensor, exp_o);
        end
    endtask

    task automatic test_signed();
        for (int n = 0; n < B; n++) i_tensor[n*IW +: IW] = 8'hFF;
        for (int k = 0; k < B*B; k++) w_tensor[k*WW +: WW] = 8'h80;
        for (int m = 0; m < B; m++) a_tensor[m*AW +: AW] = 32'd5;
        for (int m = 0; m < B; m++) exp_o[m*AW +: AW] = 32'd2053;
        run_single("signed");
    endtask

    task automatic test_wrap();
        for (int n = 0; n < B; n++) i_tensor[n*IW +: IW] = 8'd1;
        for (int k = 0; k < B*B; k++) w_tensor[k*WW +: WW] = 8'd1;
        for (int m = 0; m < B; m++) a_tensor[m*AW +: AW] = 32'h7FFF_FFFF;
        for (int m = 0; m < B; m++) exp_o[m*AW +: AW] = 32'h8000_000F;
        run_single("wrap");
    endtask

    task automatic test_mapping();
        clear_ops();
        w_tensor[(3*B+7)*WW +: WW] = 8'd2;
        i_tensor[7*IW +: IW]       = 8'd9;
        exp_o = '0;
        exp_o[3*AW +: AW] = 32'd18;
        run_single("mapping");
    endtask

    // Three back-to-back ops (o[m] = i[m] + a[m] via identity weights), then a gap.
    task automatic test_back_to_back();
        clear_ops();
        set_identity_w();
        for (int k = 0; k < 3; k++)
            for (int m = 0; m < B; m++) exp_s[k][m*AW +: AW] = AW'(m + k + 10*k);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (t >= 2 && t <= 4) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_valid_t%0d got=%b want=1", t, out_valid);
                end
                checks++;
                if (o_tensor !== exp_s[t-2]) begin
                    failures++;
                    $display("FAIL stream_data_t%0d got=%h want=%h", t, o_tensor, exp_s[t-2]);
                end
                $display("txn stream op%0d o[0]=%h", t-2, o_tensor[0 +: AW]);
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_bubble_t%0d got=%b want=0", t, out_valid);
                end
            end
            if (t == 5) begin
                checks++;
                if (o_tensor !== exp_s[2]) begin
                    failures++;
                    $display("FAIL stream_hold got=%h want=%h", o_tensor, exp_s[2]);
                end
            end
            if (t < 3) begin
                in_valid = 1'b1;
                for (int n = 0; n < B; n++) i_tensor[n*IW +: IW] = IW'(n + t);
                for (int m = 0; m < B; m++) a_tensor[m*AW +: AW] = AW'(10*t);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_ops();
        set_identity_w();
        for (int n = 0; n < B; n++) i_tensor[n*IW +: IW] = 8'd3;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (out_valid !== 1'b0 || o_tensor !== '0) begin
                failures++;
                $display("FAIL midflight_t%0d got_valid=%b got=%h want_valid=0 want=0", t, out_valid, o_tensor);
            end
            @(negedge clk);
        end
        $display("txn midflight out_valid=%b", out_valid);
        for (int m = 0; m < B; m++) exp_o[m*AW +: AW] = 32'd3;
        run_single("post_reset");
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear_ops();
        exp_o = '0;
        test_reset();
        test_identity();
        test_signed();
        test_wrap();
        test_mapping();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
